// File: rtl/exe_mem_buffer_if.sv
// exe_mem_buffer_if: EX->MEM handshake and payload bundle.
// master = execute/memory environment, slave = the buffer.
interface exe_mem_buffer_if;
  logic        exe_valid;
  logic        exe_ready;
  logic [32:0] alu_res;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        s_bit;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  dest;
  logic [31:0] st_val;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_res;
  logic        mem_wb_en;
  logic        mem_r_en_o;
  logic        mem_w_en_o;
  logic [3:0]  mem_dest;
  logic [31:0] mem_st_val;
  logic [3:0]  sr_nzcv;

  modport master (
    output exe_valid, alu_res,
    output flag_n, flag_z, flag_c, flag_v,
    output s_bit, wb_en, mem_r_en, mem_w_en,
    output dest, st_val, mem_ready,
    input  exe_ready, mem_valid, mem_alu_res,
    input  mem_wb_en, mem_r_en_o, mem_w_en_o,
    input  mem_dest, mem_st_val, sr_nzcv
  );

  modport slave (
    input  exe_valid, alu_res,
    input  flag_n, flag_z, flag_c, flag_v,
    input  s_bit, wb_en, mem_r_en, mem_w_en,
    input  dest, st_val, mem_ready,
    output exe_ready, mem_valid, mem_alu_res,
    output mem_wb_en, mem_r_en_o, mem_w_en_o,
    output mem_dest, mem_st_val, sr_nzcv
  );
endinterface

// File: rtl/exe_mem_buffer.sv
// exe_mem_buffer: EX->MEM buffer plus NZCV status register.
// Define EXE_SKID_EN for a skid entry and registered exe_ready.
module exe_mem_buffer (
  input logic             clk,
  input logic             rst_n,
  exe_mem_buffer_if.slave bus
);

  typedef struct packed {
    logic [31:0] res;
    logic        wb;
    logic        rd;
    logic        wr;
    logic [3:0]  dest;
    logic [31:0] st;
  } ent_t;

  ent_t       w_in;
  ent_t       r_head;
  logic       r_head_v;
  logic [3:0] r_sr;
  logic       w_acc;
  logic       w_dlv;
  logic       w_unused_c;

  assign w_in = {
    bus.alu_res[31:0],
    bus.wb_en,
    bus.mem_r_en,
    bus.mem_w_en,
    bus.dest,
    bus.st_val
  };
  assign w_unused_c = bus.alu_res[32];

  assign w_acc = bus.exe_valid && bus.exe_ready;
  assign w_dlv = r_head_v && bus.mem_ready;

`ifdef EXE_SKID_EN
  ent_t r_skid;
  logic r_skid_v;

  assign bus.exe_ready = !r_skid_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_head_v <= 1'b0;
      r_skid   <= '0;
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      if (w_dlv) begin
        r_head   <= r_skid;
        r_skid_v <= 1'b0;
      end
    end else if (r_head_v && !bus.mem_ready) begin
      // head stalled: park the new entry behind it
      if (w_acc) begin
        r_skid   <= w_in;
        r_skid_v <= 1'b1;
      end
    end else if (w_acc) begin
      r_head   <= w_in;
      r_head_v <= 1'b1;
    end else if (w_dlv) begin
      r_head_v <= 1'b0;
    end
  end
`else
  assign bus.exe_ready = !r_head_v || bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_head_v <= 1'b0;
    end else if (w_acc) begin
      r_head   <= w_in;
      r_head_v <= 1'b1;
    end else if (w_dlv) begin
      r_head_v <= 1'b0;
    end
  end
`endif

  // updated at accept so a following ADC sees the new carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'b0000;
    end else if (w_acc && bus.s_bit) begin
      r_sr <= {bus.flag_n, bus.flag_z,
               bus.flag_c, bus.flag_v};
    end
  end

  assign bus.mem_valid   = r_head_v;
  assign bus.mem_alu_res = r_head.res;
  assign bus.mem_wb_en   = r_head.wb;
  assign bus.mem_r_en_o  = r_head.rd;
  assign bus.mem_w_en_o  = r_head.wr;
  assign bus.mem_dest    = r_head.dest;
  assign bus.mem_st_val  = r_head.st;
  assign bus.sr_nzcv     = r_sr;

endmodule

// File: tb/tb_exe_mem_buffer.sv
// tb_exe_mem_buffer: vector table plus stall, throughput
// and async-reset sequences for exe_mem_buffer.
module tb_exe_mem_buffer;

`ifdef EXE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] q[$];

  exe_mem_buffer_if bus ();

  exe_mem_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.mem_valid && bus.mem_ready)
      q.push_back(bus.mem_alu_res);

  typedef struct {
    logic        ev;
    logic [32:0] res;
    logic [3:0]  fl;
    logic        s;
    logic [2:0]  ctl;
    logic [3:0]  dest;
    logic [31:0] st;
    logic        mr;
    logic        rdy;
    logic        mv;
    logic [31:0] eres;
    logic [2:0]  ectl;
    logic [3:0]  edest;
    logic [31:0] est;
    logic [3:0]  esr;
  } vec_t;

  vec_t tv[11];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic ev, logic [32:0] res,
                       logic [3:0] fl, logic s,
                       logic [2:0] ctl, logic [3:0] dest,
                       logic [31:0] st, logic mr);
    bus.exe_valid = ev;
    bus.alu_res   = res;
    {bus.flag_n, bus.flag_z,
     bus.flag_c, bus.flag_v} = fl;
    bus.s_bit     = s;
    {bus.wb_en, bus.mem_r_en, bus.mem_w_en} = ctl;
    bus.dest      = dest;
    bus.st_val    = st;
    bus.mem_ready = mr;
  endtask

  task automatic chk_q(string nm, logic [31:0] e0,
                       logic [31:0] e1, logic [31:0] e2,
                       int n);
    logic [31:0] ex[3];
    ex = '{e0, e1, e2};
    chk({nm, "_n"}, q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < q.size())
        chk({nm, "_e"}, q[i], ex[i]);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, '0, 4'h0, 0, 3'b000, 4'h0, '0, 0);

    tv[0]  = '{1, 33'h0_0000_0005, 4'h0, 0, 3'b100,
               4'd3, 32'h0, 0,
               1, 1, 32'h5, 3'b100, 4'd3, 32'h0, 4'h0};
    tv[1]  = '{0, 33'h0, 4'h0, 0, 3'b000, 4'd0, 32'h0, 1,
               1, 0, 32'h0, 3'b000, 4'd0, 32'h0, 4'h0};
    tv[2]  = '{1, 33'h1_0000_0000, 4'b0110, 1, 3'b010,
               4'd7, 32'h0, 1,
               1, 1, 32'h0, 3'b010, 4'd7, 32'h0, 4'b0110};
    tv[3]  = '{1, 33'h0_DEAD_BEEF, 4'b1001, 0, 3'b001,
               4'd2, 32'h1234_5678, 1,
               1, 1, 32'hDEAD_BEEF, 3'b001, 4'd2,
               32'h1234_5678, 4'b0110};
    tv[4]  = '{1, 33'h1_FFFF_FFFF, 4'b1111, 0, 3'b000,
               4'd0, 32'h0, 1,
               1, 1, 32'hFFFF_FFFF, 3'b000, 4'd0,
               32'h0, 4'b0110};
    tv[5]  = '{1, 33'h0_8000_0000, 4'b1000, 1, 3'b100,
               4'd15, 32'hA5A5_A5A5, 1,
               1, 1, 32'h8000_0000, 3'b100, 4'd15,
               32'hA5A5_A5A5, 4'b1000};
    tv[6]  = '{0, 33'h0, 4'h0, 0, 3'b000, 4'd0, 32'h0, 0,
               SKID, 1, 32'h8000_0000, 3'b100, 4'd15,
               32'hA5A5_A5A5, 4'b1000};
    tv[7]  = '{0, 33'h0, 4'h0, 0, 3'b000, 4'd0, 32'h0, 1,
               1, 0, 32'h0, 3'b000, 4'd0, 32'h0, 4'b1000};
    tv[8]  = '{0, 33'h0, 4'h0, 0, 3'b000, 4'd0, 32'h0, 1,
               1, 0, 32'h0, 3'b000, 4'd0, 32'h0, 4'b1000};
    tv[9]  = '{1, 33'h0_0000_0001, 4'b0001, 1, 3'b111,
               4'd9, 32'hFFFF_0000, 0,
               1, 1, 32'h1, 3'b111, 4'd9,
               32'hFFFF_0000, 4'b0001};
    tv[10] = '{0, 33'h0, 4'h0, 0, 3'b000, 4'd0, 32'h0, 1,
               1, 0, 32'h0, 3'b000, 4'd0, 32'h0, 4'b0001};

    #12 rst_n = 1'b1;
    #1;
    chk("rst_mv", bus.mem_valid, 0);
    chk("rst_res", bus.mem_alu_res, 0);
    chk("rst_dest", bus.mem_dest, 0);
    chk("rst_st", bus.mem_st_val, 0);
    chk("rst_ctl", {bus.mem_wb_en, bus.mem_r_en_o,
                    bus.mem_w_en_o}, 0);
    chk("rst_sr", bus.sr_nzcv, 0);
    chk("rst_rdy", bus.exe_ready, 1);
    cyc();

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].ev, tv[i].res, tv[i].fl, tv[i].s,
            tv[i].ctl, tv[i].dest, tv[i].st, tv[i].mr);
      #1;
      chk($sformatf("v%0d_rdy", i), bus.exe_ready,
          tv[i].rdy);
      cyc();
      chk($sformatf("v%0d_mv", i), bus.mem_valid, tv[i].mv);
      chk($sformatf("v%0d_sr", i), bus.sr_nzcv, tv[i].esr);
      if (tv[i].mv) begin
        chk($sformatf("v%0d_res", i), bus.mem_alu_res,
            tv[i].eres);
        chk($sformatf("v%0d_ctl", i),
            {bus.mem_wb_en, bus.mem_r_en_o, bus.mem_w_en_o},
            tv[i].ectl);
        chk($sformatf("v%0d_dest", i), bus.mem_dest,
            tv[i].edest);
        chk($sformatf("v%0d_st", i), bus.mem_st_val,
            tv[i].est);
      end
    end

    // blocked offer with s_bit=1 must not touch sr
    for (int k = 0; k < 4; k++) begin
      drive(1, 33'h10 + 33'(k), 4'h0, 0, 3'b100, 4'd1,
            32'h0, 0);
      #1;
      if (!bus.exe_ready) break;
      cyc();
    end
    chk("fill_rdy", bus.exe_ready, 0);
    drive(1, 33'h77, 4'b1110, 1, 3'b100, 4'd1, 32'h0, 0);
    cyc();
    chk("blk_sr", bus.sr_nzcv, 4'b0001);
    chk("blk_rdy", bus.exe_ready, 0);
    drive(0, 33'h0, 4'h0, 0, 3'b000, 4'd0, 32'h0, 1);
    cyc();
    cyc();
    cyc();
    chk("drain_mv", bus.mem_valid, 0);
    chk("drain_sr", bus.sr_nzcv, 4'b0001);

    q.delete();
    if (SKID) begin
      drive(1, 33'hA, 4'b0000, 0, 3'b100, 4'd1, 32'h0, 0);
      cyc();
      drive(1, 33'hB, 4'b0000, 0, 3'b100, 4'd2, 32'h0, 0);
      cyc();
      chk("sk_rdyB", bus.exe_ready, 0);
      drive(1, 33'hC, 4'b1010, 1, 3'b100, 4'd3, 32'h0, 0);
      cyc();
      cyc();
      chk("sk_rdy", bus.exe_ready, 0);
      chk("sk_head", bus.mem_alu_res, 32'hA);
      chk("sk_sr0", bus.sr_nzcv, 4'b0001);
      bus.mem_ready = 1'b1;
      cyc();
      chk("sk_head2", bus.mem_alu_res, 32'hB);
      chk("sk_rdy2", bus.exe_ready, 1);
      chk("sk_sr1", bus.sr_nzcv, 4'b0001);
      cyc();
      chk("sk_head3", bus.mem_alu_res, 32'hC);
      chk("sk_srC", bus.sr_nzcv, 4'b1010);
      bus.exe_valid = 1'b0;
      cyc();
      chk("sk_mv", bus.mem_valid, 0);
      chk_q("sk_q", 32'hA, 32'hB, 32'hC, 3);
    end else begin
      drive(1, 33'hA, 4'b0000, 0, 3'b100, 4'd1, 32'h0, 0);
      cyc();
      drive(1, 33'hB, 4'b1010, 1, 3'b100, 4'd2, 32'h0, 0);
      #1;
      chk("ns_rdy0", bus.exe_ready, 0);
      cyc();
      chk("ns_head", bus.mem_alu_res, 32'hA);
      chk("ns_sr0", bus.sr_nzcv, 4'b0001);
      bus.mem_ready = 1'b1;
      #1;
      chk("ns_rdy1", bus.exe_ready, 1);
      cyc();
      chk("ns_mv", bus.mem_valid, 1);
      chk("ns_headB", bus.mem_alu_res, 32'hB);
      chk("ns_srB", bus.sr_nzcv, 4'b1010);
      bus.exe_valid = 1'b0;
      cyc();
      chk("ns_mv0", bus.mem_valid, 0);
      chk_q("ns_q", 32'hA, 32'hB, 32'h0, 2);
    end

    q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 33'(100 + 3 * i), 4'h0, 0, 3'b100,
            4'(i), 32'h0, 1);
      cyc();
      chk($sformatf("tp_mv%0d", i), bus.mem_valid, 1);
      chk($sformatf("tp_res%0d", i), bus.mem_alu_res,
          32'(100 + 3 * i));
    end
    bus.exe_valid = 1'b0;
    cyc();
    chk("tp_end", bus.mem_valid, 0);
    chk("tp_n", q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < q.size())
        chk($sformatf("tp_q%0d", i), q[i], 32'(100 + 3 * i));

    drive(1, 33'h55, 4'b1111, 1, 3'b010, 4'd4,
          32'h99, 0);
    cyc();
    drive(1, 33'h66, 4'b1111, 1, 3'b010, 4'd5,
          32'h99, 0);
    cyc();
    bus.exe_valid = 1'b0;
    chk("ar_pre_mv", bus.mem_valid, 1);
    chk("ar_pre_sr", bus.sr_nzcv, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mv", bus.mem_valid, 0);
    chk("ar_sr", bus.sr_nzcv, 0);
    chk("ar_rdy", bus.exe_ready, 1);
    chk("ar_res", bus.mem_alu_res, 0);
    #3 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    cyc();
    chk("ar_post_mv", bus.mem_valid, 0);
    cyc();
    chk("ar_post_mv2", bus.mem_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
